// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
// Holds the handshake FSM state enum, the timeout counter width and the
// MEM/WB register bundle.
package mem_stage_pkg;

    // Handshake FSM states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Width of the ACCESS-cycle timeout counter (supports TIMEOUT_CYCLES 1..255)
    localparam int CNT_W = 8;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        reg_write;
    } memwb_t;

endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: data-memory req/ack FSM for the MEM stage.
// Owns the IDLE/ACCESS state, the ACCESS-cycle timeout counter, the dmem_*
// request outputs, the registered bus_err pulse and the done/abort strobes
// that the stage top uses to retire or bubble the instruction.
module dmem_handshake
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        start_i,      // aligned memop present (only acted on in IDLE)
    input  logic        we_i,         // store when set, load otherwise
    input  logic [31:0] addr_i,       // word-aligned address
    input  logic [31:0] wdata_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        access_o,     // FSM is in ACCESS
    output logic        done_o,       // ack seen this ACCESS cycle
    output logic        abort_o,      // last allowed ACCESS cycle passed without ack
    output logic        bus_err_o
);

    // Counter value of the final ACCESS cycle before the abort
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q;

    // State, counter and error-pulse registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= abort_o;
        end
    end

    // Next state, counter update, request outputs and completion strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        done_o  = 1'b0;
        abort_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // An ack arriving here belongs to nothing and is ignored
                if (start_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                // Request fields come straight from the held EX/MEM register
                req_o   = 1'b1;
                we_o    = we_i;
                addr_o  = addr_i;
                wdata_o = wdata_i;
                if (ack_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    abort_o = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign access_o  = (state_q == ST_ACCESS);
    assign bus_err_o = bus_err_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline.
// Consumes EX/MEM, runs loads/stores through dmem_handshake, generates the
// pipeline stall, owns the MEM/WB register and drives both forwarding sources.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN;
// without it address bits [1:0] are dropped and align_err stays 0.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_b,
    // EX/MEM register
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_z,
    input  logic [31:0] ex_rt_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    // pipeline control
    output logic        stall,
    // EX/MEM forwarding source
    output logic [4:0]  fwd_mem_rd,
    output logic [31:0] fwd_mem_rd_data,
    output logic        fwd_mem_reg_write,
    // MEM/WB register / forwarding source
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
    // data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // error pulses
    output logic        bus_err,
    output logic        align_err
);

    logic   memop;
    logic   misalign;
    logic   hs_start, hs_access, hs_done, hs_abort;
    logic   align_err_q;
    logic   rd_nz;
    memwb_t wb_q, wb_d;

    assign memop = ex_valid & (ex_mem_read | ex_mem_write);
    assign rd_nz = (ex_rd != 5'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned memop is rejected at detect time, before any request goes out
    assign misalign = memop & ~hs_access & (ex_alu_z[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign hs_start = memop & ~misalign;

    dmem_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs (
        .clk       (clk),
        .reset_b   (reset_b),
        .start_i   (hs_start),
        .we_i      (ex_mem_write),
        .addr_i    ({ex_alu_z[31:2], 2'b00}),
        .wdata_i   (ex_rt_data),
        .ack_i     (dmem_ack),
        .req_o     (dmem_req),
        .we_o      (dmem_we),
        .addr_o    (dmem_addr),
        .wdata_o   (dmem_wdata),
        .access_o  (hs_access),
        .done_o    (hs_done),
        .abort_o   (hs_abort),
        .bus_err_o (bus_err)
    );

    // Hold upstream while a memop is in flight; release on ack, timeout or align reject
    assign stall = memop & ~hs_done & ~hs_abort & ~misalign;

    // Loads are never forwarded from here; the stall covers them
    assign fwd_mem_rd        = ex_rd;
    assign fwd_mem_rd_data   = ex_alu_z;
    assign fwd_mem_reg_write = ex_valid & ex_reg_write & ~ex_mem_read & rd_nz;

    // MEM/WB next value: pass-through, load/store retire, or bubble
    always_comb begin
        wb_d = wb_q;
        if (!hs_access && !memop) begin
            wb_d.valid     = ex_valid;
            wb_d.rd        = ex_rd;
            wb_d.data      = ex_alu_z;
            wb_d.reg_write = ex_valid & ex_reg_write & rd_nz;
        end else if (hs_done) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = ex_rd;
            if (ex_mem_read) begin
                wb_d.data      = dmem_rdata;
                wb_d.reg_write = ex_reg_write & rd_nz;
            end else begin
                wb_d.data      = ex_alu_z;
                wb_d.reg_write = 1'b0;
            end
        end else begin
            // stalled, timed out or misaligned: bubble, payload holds
            wb_d.valid     = 1'b0;
            wb_d.reg_write = 1'b0;
        end
    end

    // MEM/WB register and alignment error pulse
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wb_q        <= '0;
            align_err_q <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            align_err_q <= misalign;
        end
    end

    assign wb_valid     = wb_q.valid;
    assign wb_rd        = wb_q.rd;
    assign wb_data      = wb_q.data;
    assign wb_reg_write = wb_q.reg_write;
    assign align_err    = align_err_q;

endmodule
